// File: rtl/mem_store_buffer_if.sv
// ---------------------------------------------------------------------------
// mem_store_buffer_if
// Bundles the MEM-stage store/load handshake and the data-memory port of the
// posted-write store buffer.
//   st_*      : store request from MEM (valid/ready handshake, type, addr,
//               right-aligned data, pc)
//   ld_*      : load request from MEM, stall back-pressure and raw read word
//   dm_*      : single-port word-wide data memory (combinational read dm_rdata)
//   empty     : no stores pending
// Modports:
//   slave  - the store buffer itself
//   master - the pipeline / memory side that drives requests and read data
// ---------------------------------------------------------------------------
interface mem_store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic [31:0] ld_rdata;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;
  logic        empty;

  modport slave (
    input  st_valid, st_type, st_addr, st_data, st_pc,
    input  ld_valid, ld_addr, dm_rdata,
    output st_ready, ld_stall, ld_rdata,
    output dm_we, dm_addr, dm_din, dm_pc, empty
  );

  modport master (
    output st_valid, st_type, st_addr, st_data, st_pc,
    output ld_valid, ld_addr, dm_rdata,
    input  st_ready, ld_stall, ld_rdata,
    input  dm_we, dm_addr, dm_din, dm_pc, empty
  );
endinterface

// File: rtl/mem_store_buffer.sv
// ---------------------------------------------------------------------------
// mem_store_buffer
// Posted-write buffer between the MEM stage and the word-wide data memory.
// Stores (word/half/byte) are queued in a DEPTH-entry FIFO and drained one per
// cycle whenever the memory port is not needed by an unhazarded load. Each
// drain is a read-modify-write against the memory's combinational read port.
// Loads whose word matches any pending entry are stalled until it retires.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (control state only)
//   bus  - mem_store_buffer_if.slave (store/load handshake + dm port)
//
// Optional build macro:
//   STBUF_COALESCE_EN - a store to the same word as the newest entry merges
//                       into it instead of allocating a new entry.
// ---------------------------------------------------------------------------
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_store_buffer_if.slave  bus
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  // Byte-lane mask for a store; type 11 behaves as a word.
  function automatic logic [3:0] store_mask(input logic [1:0] typ, input logic [1:0] a);
    case (typ)
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b0001 << a;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data into every lane it could occupy.
  function automatic logic [31:0] lane_data(input logic [1:0] typ, input logic [31:0] d);
    case (typ)
      2'b01:   return {2{d[15:0]}};
      2'b10:   return {4{d[7:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Control state (reset)
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  // Entry payload (no reset; qualified by vld_q)
  logic [29:0] waddr_q [DEPTH];
  logic [3:0]  mask_q  [DEPTH];
  logic [31:0] data_q  [DEPTH];
  logic [31:0] pc_q    [DEPTH];

  logic             ent_we;
  logic [PTR_W-1:0] ent_idx;
  logic [29:0]      ent_waddr_d;
  logic [3:0]       ent_mask_d;
  logic [31:0]      ent_data_d;
  logic [31:0]      ent_pc_d;

  logic        hit, drain, load, accept, alloc, merge;
  logic [3:0]  new_mask;
  logic [31:0] new_data;
  logic [31:0] head_bytes;

`ifdef STBUF_COALESCE_EN
  logic [PTR_W-1:0] tail_m1;
  logic             merge_hit;
  logic [31:0]      merge_bytes;
`endif

  always_comb begin
    // Load hazard: any pending store to the same word.
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (waddr_q[i] == bus.ld_addr[31:2])) hit = 1'b1;
    end
    hit = hit && bus.ld_valid;

    // Drain and load are mutually exclusive by construction.
    drain = (count_q != '0) && (!bus.ld_valid || hit);
    load  = bus.ld_valid && !hit;

    head_bytes   = expand_mask(mask_q[head_q]);
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_din   = '0;
    bus.dm_pc    = '0;
    bus.ld_rdata = '0;
    if (drain) begin
      bus.dm_we   = 1'b1;
      bus.dm_addr = {waddr_q[head_q], 2'b00};
      bus.dm_din  = (bus.dm_rdata & ~head_bytes) | (data_q[head_q] & head_bytes);
      bus.dm_pc   = pc_q[head_q];
    end else if (load) begin
      bus.dm_addr  = bus.ld_addr;
      bus.ld_rdata = bus.dm_rdata;
    end

    bus.ld_stall = hit;
    bus.empty    = (count_q == '0);

    new_mask = store_mask(bus.st_type, bus.st_addr[1:0]);
    new_data = lane_data(bus.st_type, bus.st_data);

`ifdef STBUF_COALESCE_EN
    tail_m1     = tail_q - 1'b1;
    merge_bytes = expand_mask(new_mask);
    // Newest entry is always valid when count != 0.
    merge_hit    = (count_q != '0) && (waddr_q[tail_m1] == bus.st_addr[31:2]);
    bus.st_ready = (count_q < DEPTH_C) || merge_hit;
    // Never merge into the entry being written to memory this cycle.
    merge        = bus.st_valid && merge_hit && !((count_q == 1) && drain);
`else
    bus.st_ready = (count_q < DEPTH_C);
    merge        = 1'b0;
`endif

    accept = bus.st_valid && bus.st_ready;
    alloc  = accept && !merge;

    ent_we      = alloc;
    ent_idx     = tail_q;
    ent_waddr_d = bus.st_addr[31:2];
    ent_mask_d  = new_mask;
    ent_data_d  = new_data;
    ent_pc_d    = bus.st_pc;
`ifdef STBUF_COALESCE_EN
    if (merge) begin
      ent_we     = 1'b1;
      ent_idx    = tail_m1;
      ent_mask_d = mask_q[tail_m1] | new_mask;
      ent_data_d = (data_q[tail_m1] & ~merge_bytes) | (new_data & merge_bytes);
    end
`endif

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    if (drain) begin
      head_d        = head_q + 1'b1;
      vld_d[head_q] = 1'b0;
    end
    if (alloc) begin
      tail_d        = tail_q + 1'b1;
      vld_d[tail_q] = 1'b1;
    end
    if (alloc && !drain)      count_d = count_q + 1'b1;
    else if (!alloc && drain) count_d = count_q - 1'b1;
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Entry payload registers
  always_ff @(posedge clk) begin
    if (ent_we) begin
      waddr_q[ent_idx] <= ent_waddr_d;
      mask_q[ent_idx]  <= ent_mask_d;
      data_q[ent_idx]  <= ent_data_d;
      pc_q[ent_idx]    <= ent_pc_d;
    end
  end

endmodule
